execute_stage: RTL and testbench



---
 rtl/execute_stage.sv | 268 ++++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the Thumb pipeline: operand forwarding, ALU with an iterative
// multiplier, NZCV flag register and the EXE/MEM pipeline register.
package execute_stage_pkg;
  typedef enum logic [1:0] {
    SRC_REG = 2'd0, SRC_IMM = 2'd1, SRC_PC = 2'd2, SRC_ACC = 2'd3
  } alu_input_source;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,  ALU_ADC = 4'd1,  ALU_SUB = 4'd2,  ALU_SBC = 4'd3,
    ALU_AND = 4'd4,  ALU_ORR = 4'd5,  ALU_EOR = 4'd6,  ALU_BIC = 4'd7,
    ALU_MOV = 4'd8,  ALU_MVN = 4'd9,  ALU_LSL = 4'd10, ALU_LSR = 4'd11,
    ALU_ASR = 4'd12, ALU_ROR = 4'd13, ALU_MUL = 4'd14
  } alu_control_signal;

  typedef logic [1:0] reg_file_data_source;
  typedef logic       update_flag_sig;
endpackage

module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  stall_i,
  input  logic                  mem_write_en_i,
  input  logic                  mem_read_en_i,
  input  logic                  reg_file_write_en_i,
  input  reg_file_data_source   reg_file_input_ctrl_sig_i,
  input  alu_input_source       alu_input_1_select_i,
  input  alu_input_source       alu_input_2_select_i,
  input  alu_control_signal     alu_control_signal_i,
  input  update_flag_sig        update_flag_i,
  input  logic [ADDR_WIDTH-1:0] reg_1_source_addr_i,
  input  logic [ADDR_WIDTH-1:0] reg_2_source_addr_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic [WORD-1:0]       reg_1_data_i,
  input  logic [WORD-1:0]       reg_2_data_i,
  input  logic [WORD-1:0]       immediate_i,
  input  logic [WORD-1:0]       accumulator_imm_i,
  input  logic [WORD-1:0]       program_counter_i,
  input  logic                  fwd_mem_en_i,
  input  logic [ADDR_WIDTH-1:0] fwd_mem_addr_i,
  input  logic [WORD-1:0]       fwd_mem_data_i,
  input  logic                  fwd_wb_en_i,
  input  logic [ADDR_WIDTH-1:0] fwd_wb_addr_i,
  input  logic [WORD-1:0]       fwd_wb_data_i,
  output logic                  busy_o,
  output logic [WORD-1:0]       alu_result_o,
  output logic [WORD-1:0]       store_data_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic                  mem_write_en_o,
  output logic                  mem_read_en_o,
  output logic                  reg_file_write_en_o,
  output reg_file_data_source   reg_file_input_ctrl_sig_o,
  output logic [3:0]            flags_o
);

  localparam int SLICE = WORD / MUL_CYCLES;
  localparam int CW    = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;
  localparam int SHW   = $clog2(WORD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL_BUSY = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WORD-1:0]       mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] lat_dest_q, lat_dest_d;
  logic                  lat_wen_q, lat_wen_d, lat_mwe_q, lat_mwe_d, lat_mre_q, lat_mre_d;
  logic                  lat_upd_q, lat_upd_d;
  reg_file_data_source   lat_src_q, lat_src_d;
  logic [WORD-1:0]       lat_store_q, lat_store_d;
  logic [WORD-1:0]       result_q, result_d, store_q, store_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                  wen_q, wen_d, mwe_q, mwe_d, mre_q, mre_d;
  reg_file_data_source   src_q, src_d;
  logic [3:0]            flags_q, flags_d;

  logic [WORD-1:0]       r1_s, r2_s, op1_s, op2_s;
  logic [WORD-1:0]       addb_s, alu_res_s, mul_a_s, mul_b_s, pp_s, mul_sum_s;
  logic                  cin_s;
  logic [WORD:0]         sum_s, lsl_w_s, lsr_w_s;
  logic signed [WORD:0]  asr_w_s;
  logic [2*WORD-1:0]     ror_w_s;
  logic [7:0]            amt_s;
  logic [3:0]            alu_flags_s;

  function automatic logic [WORD-1:0] sel_operand(input alu_input_source sel,
      input logic [WORD-1:0] regv, input logic [WORD-1:0] imm,
      input logic [WORD-1:0] pc, input logic [WORD-1:0] acc);
    case (sel)
      SRC_REG: sel_operand = regv;
      SRC_IMM: sel_operand = imm;
      SRC_PC:  sel_operand = pc;
      SRC_ACC: sel_operand = acc;
      default: sel_operand = regv;
    endcase
  endfunction

  // Forwarding: MEM beats WB beats the decode-stage register data
  always_comb begin
    if (fwd_mem_en_i && (fwd_mem_addr_i == reg_1_source_addr_i)) r1_s = fwd_mem_data_i;
    else if (fwd_wb_en_i && (fwd_wb_addr_i == reg_1_source_addr_i)) r1_s = fwd_wb_data_i;
    else r1_s = reg_1_data_i;
    if (fwd_mem_en_i && (fwd_mem_addr_i == reg_2_source_addr_i)) r2_s = fwd_mem_data_i;
    else if (fwd_wb_en_i && (fwd_wb_addr_i == reg_2_source_addr_i)) r2_s = fwd_wb_data_i;
    else r2_s = reg_2_data_i;
  end

  assign op1_s = sel_operand(alu_input_1_select_i, r1_s, immediate_i, program_counter_i, accumulator_imm_i);
  assign op2_s = sel_operand(alu_input_2_select_i, r2_s, immediate_i, program_counter_i, accumulator_imm_i);

  // Adder operand conditioning: subtraction adds the complement, carry-in from C for ADC/SBC
  always_comb begin
    addb_s = op2_s;
    cin_s  = 1'b0;
    case (alu_control_signal_i)
      ALU_ADC: cin_s = flags_q[1];
      ALU_SUB: begin addb_s = ~op2_s; cin_s = 1'b1; end
      ALU_SBC: begin addb_s = ~op2_s; cin_s = flags_q[1]; end
      default: begin addb_s = op2_s; cin_s = 1'b0; end
    endcase
  end

  assign sum_s   = {1'b0, op1_s} + {1'b0, addb_s} + {{WORD{1'b0}}, cin_s};
  assign amt_s   = op2_s[7:0];
  // The extra bit beside each shifted word catches the last bit shifted out
  assign lsl_w_s = {1'b0, op1_s} << amt_s;
  assign lsr_w_s = {op1_s, 1'b0} >> amt_s;
  assign asr_w_s = $signed({op1_s, 1'b0}) >>> amt_s;
  assign ror_w_s = {op1_s, op1_s} >> amt_s[SHW-1:0];

  // ALU result and flags for single-cycle operations
  always_comb begin
    alu_res_s   = '0;
    alu_flags_s = flags_q;
    case (alu_control_signal_i)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
        alu_res_s      = sum_s[WORD-1:0];
        alu_flags_s[1] = sum_s[WORD];
        alu_flags_s[0] = (op1_s[WORD-1] == addb_s[WORD-1]) && (sum_s[WORD-1] != op1_s[WORD-1]);
      end
      ALU_AND: alu_res_s = op1_s & op2_s;
      ALU_ORR: alu_res_s = op1_s | op2_s;
      ALU_EOR: alu_res_s = op1_s ^ op2_s;
      ALU_BIC: alu_res_s = op1_s & ~op2_s;
      ALU_MOV: alu_res_s = op2_s;
      ALU_MVN: alu_res_s = ~op2_s;
      ALU_LSL: begin
        alu_res_s = (amt_s == 8'd0) ? op1_s : lsl_w_s[WORD-1:0];
        alu_flags_s[1] = (amt_s == 8'd0) ? flags_q[1] : lsl_w_s[WORD];
      end
      ALU_LSR: begin
        alu_res_s = (amt_s == 8'd0) ? op1_s : lsr_w_s[WORD:1];
        alu_flags_s[1] = (amt_s == 8'd0) ? flags_q[1] : lsr_w_s[0];
      end
      ALU_ASR: begin
        alu_res_s = (amt_s == 8'd0) ? op1_s : asr_w_s[WORD:1];
        alu_flags_s[1] = (amt_s == 8'd0) ? flags_q[1] : asr_w_s[0];
      end
      ALU_ROR: begin
        alu_res_s = (amt_s == 8'd0) ? op1_s : ror_w_s[WORD-1:0];
        alu_flags_s[1] = (amt_s == 8'd0) ? flags_q[1] : ror_w_s[WORD-1];
      end
      default: alu_res_s = '0;
    endcase
    alu_flags_s[3] = alu_res_s[WORD-1];
    alu_flags_s[2] = (alu_res_s == '0);
  end

  // One multiplier slice per step; step 0 comes straight from the operand mux
  always_comb begin
    if (state_q == ST_IDLE) begin
      mul_a_s = op1_s;
      mul_b_s = {{(WORD-SLICE){1'b0}}, op2_s[SLICE-1:0]};
    end else begin
      mul_a_s = mcand_q;
      mul_b_s = {{(WORD-SLICE){1'b0}}, mplier_q[SLICE-1:0]};
    end
  end

  assign pp_s      = mul_a_s * mul_b_s;
  assign mul_sum_s = ((state_q == ST_IDLE) ? '0 : acc_q) + pp_s;

  // Next-state for the FSM, multiplier, latched controls, output register and flags
  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;
    mcand_d = mcand_q;   mplier_d = mplier_q;   acc_d = acc_q;
    lat_dest_d = lat_dest_q; lat_wen_d = lat_wen_q; lat_mwe_d = lat_mwe_q;
    lat_mre_d = lat_mre_q;   lat_upd_d = lat_upd_q; lat_src_d = lat_src_q;
    lat_store_d = lat_store_q;
    result_d = result_q; store_d = store_q; dest_d = dest_q; src_d = src_q;
    wen_d = wen_q; mwe_d = mwe_q; mre_d = mre_q; flags_d = flags_q;
    if (!stall_i) begin
      case (state_q)
        ST_IDLE: begin
          if (alu_control_signal_i == ALU_MUL) begin
            state_d = ST_MUL_BUSY;  cnt_d = CW'(1);
            mcand_d = op1_s << SLICE; mplier_d = op2_s >> SLICE; acc_d = mul_sum_s;
            lat_dest_d = reg_dest_addr_i; lat_wen_d = reg_file_write_en_i;
            lat_mwe_d = mem_write_en_i;   lat_mre_d = mem_read_en_i;
            lat_upd_d = update_flag_i;    lat_src_d = reg_file_input_ctrl_sig_i;
            lat_store_d = r2_s;
            wen_d = 1'b0; mwe_d = 1'b0; mre_d = 1'b0;
          end else begin
            result_d = alu_res_s; store_d = r2_s; dest_d = reg_dest_addr_i;
            src_d = reg_file_input_ctrl_sig_i; wen_d = reg_file_write_en_i;
            mwe_d = mem_write_en_i; mre_d = mem_read_en_i;
            flags_d = update_flag_i ? alu_flags_s : flags_q;
          end
        end
        ST_MUL_BUSY: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE; cnt_d = '0;
            result_d = mul_sum_s; store_d = lat_store_q; dest_d = lat_dest_q;
            src_d = lat_src_q; wen_d = lat_wen_q; mwe_d = lat_mwe_q; mre_d = lat_mre_q;
            flags_d = lat_upd_q ? {mul_sum_s[WORD-1], (mul_sum_s == '0), flags_q[1:0]} : flags_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
            mcand_d = mcand_q << SLICE; mplier_d = mplier_q >> SLICE; acc_d = mul_sum_s;
            wen_d = 1'b0; mwe_d = 1'b0; mre_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE; cnt_d = '0;
          wen_d = 1'b0; mwe_d = 1'b0; mre_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State register; reset abandons any multiply in progress
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE; cnt_q <= '0;
      mcand_q <= '0; mplier_q <= '0; acc_q <= '0;
      lat_dest_q <= '0; lat_wen_q <= 1'b0; lat_mwe_q <= 1'b0; lat_mre_q <= 1'b0;
      lat_upd_q <= 1'b0; lat_src_q <= '0; lat_store_q <= '0;
      result_q <= '0; store_q <= '0; dest_q <= '0; src_q <= '0;
      wen_q <= 1'b0; mwe_q <= 1'b0; mre_q <= 1'b0; flags_q <= 4'b0000;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;
      mcand_q <= mcand_d; mplier_q <= mplier_d; acc_q <= acc_d;
      lat_dest_q <= lat_dest_d; lat_wen_q <= lat_wen_d; lat_mwe_q <= lat_mwe_d;
      lat_mre_q <= lat_mre_d; lat_upd_q <= lat_upd_d; lat_src_q <= lat_src_d;
      lat_store_q <= lat_store_d;
      result_q <= result_d; store_q <= store_d; dest_q <= dest_d; src_q <= src_d;
      wen_q <= wen_d; mwe_q <= mwe_d; mre_q <= mre_d; flags_q <= flags_d;
    end
  end

  assign busy_o                    = (state_q == ST_MUL_BUSY);
  assign alu_result_o              = result_q;
  assign store_data_o              = store_q;
  assign reg_dest_addr_o           = dest_q;
  assign mem_write_en_o            = mwe_q;
  assign mem_read_en_o             = mre_q;
  assign reg_file_write_en_o       = wen_q;
  assign reg_file_input_ctrl_sig_o = src_q;
  assign flags_o                   = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU ops, flags, forwarding, multiply, stall and reset.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i, stall_i;
  logic mem_write_en_i, mem_read_en_i, reg_file_write_en_i;
  reg_file_data_source reg_file_input_ctrl_sig_i;
  alu_input_source alu_input_1_select_i, alu_input_2_select_i;
  alu_control_signal alu_control_signal_i;
  update_flag_sig update_flag_i;
  logic [3:0] reg_1_source_addr_i, reg_2_source_addr_i, reg_dest_addr_i;
  logic [31:0] reg_1_data_i, reg_2_data_i, immediate_i, accumulator_imm_i, program_counter_i;
  logic fwd_mem_en_i, fwd_wb_en_i;
  logic [3:0] fwd_mem_addr_i, fwd_wb_addr_i;
  logic [31:0] fwd_mem_data_i, fwd_wb_data_i;
  logic busy_o;
  logic [31:0] alu_result_o, store_data_o;
  logic [3:0] reg_dest_addr_o;
  logic mem_write_en_o, mem_read_en_o, reg_file_write_en_o;
  reg_file_data_source reg_file_input_ctrl_sig_o;
  logic [3:0] flags_o;

  int n_cmp = 0;
  int n_err = 0;

  execute_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i),
    .mem_write_en_i(mem_write_en_i), .mem_read_en_i(mem_read_en_i),
    .reg_file_write_en_i(reg_file_write_en_i),
    .reg_file_input_ctrl_sig_i(reg_file_input_ctrl_sig_i),
    .alu_input_1_select_i(alu_input_1_select_i), .alu_input_2_select_i(alu_input_2_select_i),
    .alu_control_signal_i(alu_control_signal_i), .update_flag_i(update_flag_i),
    .reg_1_source_addr_i(reg_1_source_addr_i), .reg_2_source_addr_i(reg_2_source_addr_i),
    .reg_dest_addr_i(reg_dest_addr_i),
    .reg_1_data_i(reg_1_data_i), .reg_2_data_i(reg_2_data_i), .immediate_i(immediate_i),
    .accumulator_imm_i(accumulator_imm_i), .program_counter_i(program_counter_i),
    .fwd_mem_en_i(fwd_mem_en_i), .fwd_mem_addr_i(fwd_mem_addr_i), .fwd_mem_data_i(fwd_mem_data_i),
    .fwd_wb_en_i(fwd_wb_en_i), .fwd_wb_addr_i(fwd_wb_addr_i), .fwd_wb_data_i(fwd_wb_data_i),
    .busy_o(busy_o), .alu_result_o(alu_result_o), .store_data_o(store_data_o),
    .reg_dest_addr_o(reg_dest_addr_o), .mem_write_en_o(mem_write_en_o),
    .mem_read_en_o(mem_read_en_o), .reg_file_write_en_o(reg_file_write_en_o),
    .reg_file_input_ctrl_sig_o(reg_file_input_ctrl_sig_o), .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input alu_control_signal op, input alu_input_source s1,
                       input alu_input_source s2, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm,
                       input logic upd, input logic [3:0] dest);
    alu_control_signal_i = op;  alu_input_1_select_i = s1; alu_input_2_select_i = s2;
    reg_1_data_i = r1; reg_2_data_i = r2; immediate_i = imm;
    update_flag_i = upd; reg_dest_addr_i = dest; reg_file_write_en_i = 1'b1;
  endtask

  initial begin
    reset_i = 1'b0; stall_i = 1'b0;
    mem_write_en_i = 1'b0; mem_read_en_i = 1'b0; reg_file_write_en_i = 1'b0;
    reg_file_input_ctrl_sig_i = 2'd1;
    reg_1_source_addr_i = 4'd1; reg_2_source_addr_i = 4'd2;
    accumulator_imm_i = 32'h0; program_counter_i = 32'h100;
    fwd_mem_en_i = 1'b0; fwd_mem_addr_i = 4'd0; fwd_mem_data_i = 32'h0;
    fwd_wb_en_i = 1'b0;  fwd_wb_addr_i = 4'd0;  fwd_wb_data_i = 32'h0;
    drive(ALU_ADD, SRC_REG, SRC_REG, 32'h0, 32'h0, 32'h0, 1'b0, 4'd0);

    repeat (2) tick();
    check_value("rst_result", alu_result_o, 32'h0);
    check_value("rst_flags", {28'h0, flags_o}, 32'h0);
    check_value("rst_busy", {31'h0, busy_o}, 32'h0);
    check_value("rst_wen", {31'h0, reg_file_write_en_o}, 32'h0);
    reset_i = 1'b1;

    drive(ALU_ADD, SRC_REG, SRC_REG, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b1, 4'd2);
    tick();
    check_value("add_result", alu_result_o, 32'h80000000);
    check_value("add_flags", {28'h0, flags_o}, 32'h9);
    check_value("add_dest", {28'h0, reg_dest_addr_o}, 32'h2);
    check_value("add_wen", {31'h0, reg_file_write_en_o}, 32'h1);
    check_value("add_src", {30'h0, reg_file_input_ctrl_sig_o}, 32'h1);

    drive(ALU_SUB, SRC_REG, SRC_IMM, 32'h5, 32'h0, 32'h5, 1'b1, 4'd3);
    tick();
    check_value("sub_result", alu_result_o, 32'h0);
    check_value("sub_flags", {28'h0, flags_o}, 32'h6);

    drive(ALU_ADC, SRC_REG, SRC_IMM, 32'h1, 32'h0, 32'h2, 1'b1, 4'd3);
    tick();
    check_value("adc_result", alu_result_o, 32'h4);
    check_value("adc_flags", {28'h0, flags_o}, 32'h0);

    reg_1_source_addr_i = 4'd3;
    fwd_mem_en_i = 1'b1; fwd_mem_addr_i = 4'd3; fwd_mem_data_i = 32'h10;
    fwd_wb_en_i = 1'b1;  fwd_wb_addr_i = 4'd3;  fwd_wb_data_i = 32'h20;
    drive(ALU_ADD, SRC_REG, SRC_IMM, 32'h30, 32'h0, 32'h1, 1'b0, 4'd5);
    tick();
    check_value("fwd_mem", alu_result_o, 32'h11);
    fwd_mem_en_i = 1'b0;
    tick();
    check_value("fwd_wb", alu_result_o, 32'h21);
    fwd_wb_addr_i = 4'd4;
    tick();
    check_value("fwd_none", alu_result_o, 32'h31);
    check_value("fwd_flags_held", {28'h0, flags_o}, 32'h0);
    fwd_wb_en_i = 1'b0; reg_1_source_addr_i = 4'd1;

    drive(ALU_SUB, SRC_REG, SRC_IMM, 32'h5, 32'h0, 32'h5, 1'b1, 4'd3);
    tick();
    drive(ALU_ORR, SRC_REG, SRC_IMM, 32'h80000000, 32'h0, 32'h0, 1'b1, 4'd3);
    tick();
    check_value("orr_result", alu_result_o, 32'h80000000);
    check_value("orr_flags", {28'h0, flags_o}, 32'hA);

    drive(ALU_LSL, SRC_REG, SRC_IMM, 32'h80000001, 32'h0, 32'd1, 1'b1, 4'd3);
    tick();
    check_value("lsl_result", alu_result_o, 32'h2);
    check_value("lsl_flags", {28'h0, flags_o}, 32'h2);
    drive(ALU_LSR, SRC_REG, SRC_IMM, 32'h1, 32'h0, 32'd40, 1'b1, 4'd3);
    tick();
    check_value("lsr40_result", alu_result_o, 32'h0);
    check_value("lsr40_flags", {28'h0, flags_o}, 32'h4);
    drive(ALU_ASR, SRC_REG, SRC_IMM, 32'h80000000, 32'h0, 32'd33, 1'b1, 4'd3);
    tick();
    check_value("asr33_result", alu_result_o, 32'hFFFFFFFF);
    check_value("asr33_flags", {28'h0, flags_o}, 32'hA);
    drive(ALU_ROR, SRC_REG, SRC_IMM, 32'h1, 32'h0, 32'd1, 1'b1, 4'd3);
    tick();
    check_value("ror_result", alu_result_o, 32'h80000000);
    drive(ALU_LSL, SRC_REG, SRC_IMM, 32'h5, 32'h0, 32'd0, 1'b1, 4'd3);
    tick();
    check_value("lsl0_result", alu_result_o, 32'h5);
    check_value("lsl0_flags", {28'h0, flags_o}, 32'h2);

    drive(ALU_MUL, SRC_REG, SRC_IMM, 32'h12345678, 32'h0, 32'h10, 1'b1, 4'd7);
    tick();
    check_value("mul_e0_busy", {31'h0, busy_o}, 32'h1);
    check_value("mul_e0_wen", {31'h0, reg_file_write_en_o}, 32'h0);
    check_value("mul_e0_result_held", alu_result_o, 32'h5);
    drive(ALU_ADD, SRC_REG, SRC_IMM, 32'hDEAD0000, 32'h0, 32'h1, 1'b0, 4'd9);
    for (int i = 1; i < 3; i++) begin
      tick();
      check_value($sformatf("mul_e%0d_busy", i), {31'h0, busy_o}, 32'h1);
      check_value($sformatf("mul_e%0d_wen", i), {31'h0, reg_file_write_en_o}, 32'h0);
    end
    tick();
    check_value("mul_busy_done", {31'h0, busy_o}, 32'h0);
    check_value("mul_result", alu_result_o, 32'h23456780);
    check_value("mul_wen", {31'h0, reg_file_write_en_o}, 32'h1);
    check_value("mul_dest", {28'h0, reg_dest_addr_o}, 32'h7);
    check_value("mul_flags", {28'h0, flags_o}, 32'h2);

    stall_i = 1'b1;
    drive(ALU_ADD, SRC_REG, SRC_IMM, 32'h1, 32'h0, 32'h1, 1'b1, 4'd1);
    tick();
    check_value("stall_idle_hold", alu_result_o, 32'h23456780);
    stall_i = 1'b0;

    drive(ALU_MUL, SRC_REG, SRC_IMM, 32'h3, 32'h0, 32'h01010101, 1'b0, 4'd8);
    tick();
    drive(ALU_ADD, SRC_REG, SRC_IMM, 32'h0, 32'h0, 32'h0, 1'b0, 4'd9);
    tick();
    stall_i = 1'b1;
    tick();
    tick();
    check_value("stall_mul_busy", {31'h0, busy_o}, 32'h1);
    check_value("stall_mul_wen", {31'h0, reg_file_write_en_o}, 32'h0);
    stall_i = 1'b0;
    tick();
    check_value("stall_mul_e2_busy", {31'h0, busy_o}, 32'h1);
    check_value("stall_mul_e2_wen", {31'h0, reg_file_write_en_o}, 32'h0);
    tick();
    check_value("stall_mul_done", {31'h0, busy_o}, 32'h0);
    check_value("stall_mul_result", alu_result_o, 32'h03030303);
    check_value("stall_mul_dest", {28'h0, reg_dest_addr_o}, 32'h8);
    check_value("stall_mul_flags", {28'h0, flags_o}, 32'h2);

    drive(ALU_MUL, SRC_REG, SRC_IMM, 32'h12345678, 32'h0, 32'h10, 1'b1, 4'd7);
    tick();
    check_value("rmul_busy", {31'h0, busy_o}, 32'h1);
    #2 reset_i = 1'b0;
    #1;
    check_value("rmul_busy_clr", {31'h0, busy_o}, 32'h0);
    check_value("rmul_result_clr", alu_result_o, 32'h0);
    check_value("rmul_flags_clr", {28'h0, flags_o}, 32'h0);
    check_value("rmul_dest_clr", {28'h0, reg_dest_addr_o}, 32'h0);
    #2 reset_i = 1'b1;
    drive(ALU_ADD, SRC_REG, SRC_IMM, 32'h2, 32'h0, 32'h3, 1'b1, 4'd4);
    tick();
    check_value("post_rst_result", alu_result_o, 32'h5);
    check_value("post_rst_wen", {31'h0, reg_file_write_en_o}, 32'h1);
    check_value("post_rst_dest", {28'h0, reg_dest_addr_o}, 32'h4);
    check_value("post_rst_busy", {31'h0, busy_o}, 32'h0);
    check_value("post_rst_flags", {28'h0, flags_o}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
